mont_mult: RTL and testbench

- Iterative radix-2 Montgomery multiplier. Computes result = a·b·R⁻¹ mod N, with R = 2^WIDTH.
- Sits directly upstream of mont_reduction and produces the Montgomery-form operands that mont_reduction converts back to natural numbers.
- Used for the modular products in exponentiation.
- Handshake: start/valid with a busy flag. One operation in flight at a time.

---
 rtl/mont_mult.sv | 110 +++++++++++
 tb/tb_mont_mult.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod N, one operand bit per cycle.
// Latency WIDTH+1 cycles from accepted start to valid pulse; start is ignored while busy.
module mont_mult #(
    parameter int WIDTH = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] N_in,
    output logic             busy_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        FINAL
    } state_t;

    state_t state, state_nxt;
    logic   load, step, finish;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH+1:0] s_r;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic [WIDTH-1:0] res_fin;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        busy_out  = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_in) begin
                    load      = 1'b1;
                    state_nxt = LOOP;
                end
            end
            LOOP: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A is consumed LSB first by shifting it down, so the current bit is always a_sh[0].
    always_comb begin
        n_ext   = {2'b00, n_r};
        t_add   = s_r + (a_sh[0] ? {2'b00, b_r} : '0);
        t_red   = t_add[0] ? (t_add + n_ext) : t_add;
        res_fin = WIDTH'((s_r >= n_ext) ? (s_r - n_ext) : s_r);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            a_sh       <= '0;
            b_r        <= '0;
            n_r        <= '0;
            s_r        <= '0;
            cnt        <= '0;
            valid_out  <= 1'b0;
            result_out <= '0;
        end else begin
            valid_out <= finish;
            if (load) begin
                a_sh <= a_in;
                b_r  <= b_in;
                n_r  <= N_in;
                s_r  <= '0;
                cnt  <= '0;
            end else if (step) begin
                a_sh <= a_sh >> 1;
                s_r  <= t_red >> 1;
                cnt  <= cnt + CW'(1);
            end
            if (finish) begin
                result_out <= res_fin;
            end
        end
    end

endmodule

// File: tb/tb_mont_mult.sv
// Bench for mont_mult at WIDTH=16 and WIDTH=512 against a word-level Montgomery reference.
module tb_mont_mult;

    typedef logic [1039:0] big_t;

    logic         clk;
    logic         rst;
    logic         s16;
    logic [15:0]  a16, b16, n16;
    logic         busy16, vld16;
    logic [15:0]  res16;
    logic         s5;
    logic [511:0] a5, b5, n5;
    logic         busy5, vld5;
    logic [511:0] res5;

    int checks   = 0;
    int failures = 0;

    mont_mult #(.WIDTH(16)) u16 (
        .clk_in(clk), .rst_in(rst), .start_in(s16),
        .a_in(a16), .b_in(b16), .N_in(n16),
        .busy_out(busy16), .valid_out(vld16), .result_out(res16)
    );

    mont_mult #(.WIDTH(512)) u512 (
        .clk_in(clk), .rst_in(rst), .start_in(s5),
        .a_in(a5), .b_in(b5), .N_in(n5),
        .busy_out(busy5), .valid_out(vld5), .result_out(res5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // REDC on whole numbers: t = a*b, m = t*(-N^-1) mod R, u = (t + m*N)/R, conditionally minus N.
    function automatic big_t mont_ref(input big_t a, input big_t b, input big_t n, input int w);
        big_t mask, inv, nprime, t, m, u;
        mask = (big_t'(1) << w) - big_t'(1);
        inv  = n;
        for (int k = 0; k < 10; k++) begin
            inv = (inv * (big_t'(2) - ((n * inv) & mask))) & mask;
        end
        nprime = (big_t'(0) - inv) & mask;
        t = a * b;
        m = ((t & mask) * nprime) & mask;
        u = (t + m * n) >> w;
        if (u >= n) u = u - n;
        return u;
    endfunction

    task automatic check(input string tag, input big_t obs, input big_t exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!vld16 && lat < 200);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n,
                        output int lat);
        a16 = a;
        b16 = b;
        n16 = n;
        s16 = 1'b1;
        @(posedge clk);
        #1;
        s16 = 1'b0;
        wait16(lat);
    endtask

    task automatic op512(input big_t a, input big_t b, input big_t n, output int lat);
        a5 = a[511:0];
        b5 = b[511:0];
        n5 = n[511:0];
        s5 = 1'b1;
        @(posedge clk);
        #1;
        s5  = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!vld5 && lat < 1000);
    endtask

    initial begin
        int   lat, pulses;
        big_t nbig, xbig, ra, rb;
        logic [15:0] n_small;

        n_small = 16'd33227;
        rst = 1'b0;
        s16 = 1'b1;
        a16 = 16'd5;
        b16 = 16'd7;
        n16 = n_small;
        s5  = 1'b1;
        a5  = '0;
        b5  = '0;
        n5  = 512'd3;

        // Reset must win over start on the same edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy16", big_t'(busy16), big_t'(0));
        check("rst_valid16", big_t'(vld16), big_t'(0));
        check("rst_result16", big_t'(res16), big_t'(0));
        check("rst_busy512", big_t'(busy5), big_t'(0));
        s16 = 1'b0;
        s5  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy16", big_t'(busy16), big_t'(0));

        op16(16'd24226, 16'd1, n_small, lat);
        check("from_mont_46", big_t'(res16), big_t'(46));
        check("lat16", big_t'(lat), big_t'(17));
        @(posedge clk);
        #1;
        check("valid_one_cycle", big_t'(vld16), big_t'(0));
        check("result_hold", big_t'(res16), big_t'(46));

        op16(16'd32309, 16'd24226, n_small, lat);
        check("mont_one_times", big_t'(res16), big_t'(24226));
        op16(16'd0, 16'd12345, n_small, lat);
        check("a_zero", big_t'(res16), big_t'(0));
        op16(16'd33226, 16'd33226, n_small, lat);
        check("max_operands", big_t'(res16), mont_ref(big_t'(33226), big_t'(33226), big_t'(n_small), 16));

        for (int k = 0; k < 6; k++) begin
            ra = big_t'($urandom_range(33226, 0));
            rb = big_t'($urandom_range(33226, 0));
            op16(ra[15:0], rb[15:0], n_small, lat);
            check("rand16", big_t'(res16), mont_ref(ra, rb, big_t'(n_small), 16));
            check("rand16_lat", big_t'(lat), big_t'(17));
        end

        // Start held high with a re-pulse at cycle 5 and operand changes mid-operation.
        a16 = 16'd24226;
        b16 = 16'd1;
        n16 = n_small;
        s16 = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            if (c < 17 && vld16) pulses++;
            if (c == 4) s16 = 1'b0;
            if (c == 5) begin
                s16 = 1'b1;
                a16 = 16'd777;
                b16 = 16'd999;
                n16 = 16'd1001;
            end
            if (c == 8) check("busy_mid_op", big_t'(busy16), big_t'(1));
        end
        check("no_early_valid", big_t'(pulses), big_t'(0));
        check("held_start_valid17", big_t'(vld16), big_t'(1));
        check("held_start_result", big_t'(res16), big_t'(46));
        a16 = 16'd32309;
        b16 = 16'd24226;
        n16 = n_small;
        @(posedge clk);
        #1;
        s16 = 1'b0;
        wait16(lat);
        check("b2b_lat", big_t'(lat), big_t'(17));
        check("b2b_result", big_t'(res16), big_t'(24226));

        // Abort at iteration 8.
        a16 = 16'd33226;
        b16 = 16'd33226;
        s16 = 1'b1;
        @(posedge clk);
        #1;
        s16 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", big_t'(busy16), big_t'(0));
        check("abort_valid", big_t'(vld16), big_t'(0));
        check("abort_result", big_t'(res16), big_t'(0));
        rst = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (vld16) pulses++;
        end
        check("abort_no_pulse", big_t'(pulses), big_t'(0));
        op16(16'd33226, 16'd33226, n_small, lat);
        check("after_reset", big_t'(res16), mont_ref(big_t'(33226), big_t'(33226), big_t'(n_small), 16));
        check("after_reset_lat", big_t'(lat), big_t'(17));

        nbig = big_t'(512'd8446001084112110468007350899866059366449315229085619820000217473402760874334633786644317357840696578249028889585050688594982676710791149734896799707926013);
        xbig = big_t'(512'd82289494155958622552101842259948196324913095467108646453504357986875686437490);
        op512((xbig << 512) % nbig, big_t'(1), nbig, lat);
        check("w512_from_mont", big_t'(res5), xbig);
        check("w512_lat", big_t'(lat), big_t'(513));

        for (int k = 0; k < 100; k++) begin
            ra = '0;
            rb = '0;
            for (int j = 0; j < 16; j++) begin
                ra = (ra << 32) | big_t'($urandom());
                rb = (rb << 32) | big_t'($urandom());
            end
            ra = ra % nbig;
            rb = rb % nbig;
            op512(ra, rb, nbig, lat);
            check("w512_rand", big_t'(res5), mont_ref(ra, rb, nbig, 512));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
